// File: rtl/npu_sram_pkg.sv
// npu_sram_pkg -- shared types and helpers for the npu_sram_dp buffer.
//   sram_state_t   : zero-init engine state (INIT, RUN)
//   clog2()        : ceiling log2, usable in localparam expressions
//   READ_LAT_MIN/MAX, read_lat_legal() : legal read-latency range
package npu_sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit read_lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/npu_sram_init_fsm.sv
// npu_sram_init_fsm -- zero-init sequencer for npu_sram_dp.
// Sweeps every word address once after reset or a clr request, and tells
// the top which source owns the array write port.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   clr        in   restart the sweep (only honoured in RUN)
//   init_busy  out  registered, high while the sweep runs
//   init_wr    out  write-mux select: 1 = init engine owns the write port
//   init_addr  out  word address currently being cleared
module npu_sram_init_fsm
  import npu_sram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          init_busy,
  output logic          init_wr,
  output logic [IW-1:0] init_addr
);

  // state | meaning
  // ------+------------------------------------------------------------
  // INIT  | writing zero to init_addr each cycle, user ports blocked
  // RUN   | user read/write ports live, clr restarts the sweep

  localparam logic [IW-1:0] LAST_ADDR = IW'(DEPTH - 1);

  sram_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_addr <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (init_addr == LAST_ADDR) begin
            state     <= RUN;
            init_addr <= '0;
            init_busy <= 1'b0;
          end else begin
            init_addr <= init_addr + IW'(1);
          end
        end
        RUN: begin
          if (clr) begin
            state     <= INIT;
            init_addr <= '0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= INIT;
          init_addr <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign init_wr = (state == INIT);

endmodule

// File: rtl/npu_sram_dp.sv
// npu_sram_dp -- single-clock simple dual-port SRAM for NPU buffers.
// Write port fed by DMA/loader, read port feeds the compute datapath.
// Byte-masked writes, write-first forwarding on same-address collisions,
// READ_LAT (1 or 2) cycle read pipeline with rd_valid, and a zero-init
// engine that clears the whole array after reset or a clr pulse.
// Ports:
//   clk        in   sole clock
//   rst        in   asynchronous reset, active-high
//   clr        in   re-run zero-init (ignored while init_busy)
//   wr_en      in   write request
//   wr_addr    in   [AW]   write address (>= DEPTH is dropped)
//   wr_be      in   [DW/8] byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data    in   [DW]   write data
//   rd_en      in   read request
//   rd_addr    in   [AW]   read address (>= DEPTH reads back zero)
//   rd_data    out  [DW]   read data, held until the next valid read
//   rd_valid   out  one-cycle pulse READ_LAT cycles after an accepted read
//   init_busy  out  high while the zero-init engine runs
//   parity_err out  (NPU_SRAM_PARITY_EN only) byte parity mismatch, with rd_valid
// Build option: define NPU_SRAM_PARITY_EN to store one even-parity bit per byte.
module npu_sram_dp
  import npu_sram_pkg::*;
#(
  parameter int DW       = 128,
  parameter int DEPTH    = 4096,
  parameter int AW       = 12,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
`ifdef NPU_SRAM_PARITY_EN
  output logic            parity_err,
`endif
  output logic            init_busy
);

  localparam int NB  = DW / 8;
  // A one-word array still needs a one-bit index.
  localparam int IW  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_V = AW1'(DEPTH);
  // An out-of-range READ_LAT falls back to the single-stage pipeline.
  localparam bit LAT2 = read_lat_legal(READ_LAT) && (READ_LAT == 2);

  logic [DW-1:0] mem [DEPTH];
`ifdef NPU_SRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
`endif

  logic          init_wr;
  logic [IW-1:0] init_addr;

  npu_sram_init_fsm #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_init (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .init_busy (init_busy),
    .init_wr   (init_wr),
    .init_addr (init_addr)
  );

  // Write port mux: the init engine owns the array while it runs.
  logic          wr_in_range;
  logic          usr_wr;
  logic          arr_we;
  logic [IW-1:0] arr_idx;
  logic [NB-1:0] arr_be;
  logic [DW-1:0] arr_din;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
  assign usr_wr      = wr_en & ~init_wr & wr_in_range;
  assign arr_we      = init_wr | usr_wr;
  assign arr_idx     = init_wr ? init_addr : wr_addr[IW-1:0];
  assign arr_be      = init_wr ? '1 : wr_be;
  assign arr_din     = init_wr ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int i = 0; i < NB; i++) begin
        if (arr_be[i]) begin
          mem[arr_idx][8*i +: 8] <= arr_din[8*i +: 8];
`ifdef NPU_SRAM_PARITY_EN
          par[arr_idx][i] <= ^arr_din[8*i +: 8];
`endif
        end
      end
    end
  end

  // Read port: array word with same-cycle write bytes forwarded over it.
  logic          rd_ok;
  logic          rd_in_range;
  logic          fwd;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_word;

  assign rd_ok       = rd_en & ~init_wr;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);
  assign fwd         = usr_wr & (wr_addr == rd_addr);
  assign rd_idx      = rd_addr[IW-1:0];

`ifdef NPU_SRAM_PARITY_EN
  logic [NB-1:0] rd_pbits;
  logic          rd_perr;
`endif

  always_comb begin
    rd_word = '0;
`ifdef NPU_SRAM_PARITY_EN
    rd_pbits = '0;
    rd_perr  = 1'b0;
`endif
    if (rd_in_range) begin
      rd_word = mem[rd_idx];
`ifdef NPU_SRAM_PARITY_EN
      rd_pbits = par[rd_idx];
`endif
      for (int i = 0; i < NB; i++) begin
        if (fwd && wr_be[i]) begin
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
`ifdef NPU_SRAM_PARITY_EN
          rd_pbits[i] = ^wr_data[8*i +: 8];
`endif
        end
      end
`ifdef NPU_SRAM_PARITY_EN
      for (int i = 0; i < NB; i++) begin
        if ((^rd_word[8*i +: 8]) != rd_pbits[i]) begin
          rd_perr = 1'b1;
        end
      end
`endif
    end
  end

  // First pipeline stage. clr does not flush it, so in-flight reads finish.
  logic [DW-1:0] s1_data;
  logic          s1_valid;
`ifdef NPU_SRAM_PARITY_EN
  logic          s1_perr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
`ifdef NPU_SRAM_PARITY_EN
      s1_perr  <= 1'b0;
`endif
    end else begin
      s1_valid <= rd_ok;
`ifdef NPU_SRAM_PARITY_EN
      s1_perr  <= rd_ok & rd_perr;
`endif
      if (rd_ok) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (LAT2) begin : g_lat2
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data    <= '0;
          rd_valid   <= 1'b0;
`ifdef NPU_SRAM_PARITY_EN
          parity_err <= 1'b0;
`endif
        end else begin
          rd_valid   <= s1_valid;
`ifdef NPU_SRAM_PARITY_EN
          parity_err <= s1_perr;
`endif
          if (s1_valid) begin
            rd_data <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      assign rd_data    = s1_data;
      assign rd_valid   = s1_valid;
`ifdef NPU_SRAM_PARITY_EN
      assign parity_err = s1_perr;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_npu_sram_dp.sv
// Two instances (READ_LAT=1 and READ_LAT=2, DEPTH=3000) share one stimulus
// stream and are checked every cycle against a word-level memory model.
module tb_npu_sram_dp;
  localparam int DW    = 128;
  localparam int DEPTH = 3000;
  localparam int AW    = 12;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          busy0, busy1;
`ifdef NPU_SRAM_PARITY_EN
  logic          perr0, perr1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  npu_sram_dp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .READ_LAT(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
`ifdef NPU_SRAM_PARITY_EN
    .parity_err(perr0),
`endif
    .init_busy(busy0)
  );

  npu_sram_dp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .READ_LAT(2)) u1 (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
`ifdef NPU_SRAM_PARITY_EN
    .parity_err(perr1),
`endif
    .init_busy(busy1)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Zero-init is modelled as "array cleared at once, ports blocked for DEPTH
  // edges"; reads are queued with the edge number at which they must appear.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic          pe;
  } rd_t;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_busy_left;
  int            m_bad = -1;
  int            ec = 0;
  rd_t           q0[$];
  rd_t           q1[$];
  logic          m_v0, m_v1, m_p0, m_p1;
  logic [DW-1:0] m_d0, m_d1;

  always @(posedge clk or posedge rst) begin
    rd_t e;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy_left = DEPTH;
      m_bad = -1;
      q0.delete();
      q1.delete();
      m_v0 = 1'b0; m_v1 = 1'b0; m_p0 = 1'b0; m_p1 = 1'b0;
      m_d0 = '0;   m_d1 = '0;
    end else begin
      ec++;
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else begin
        if (rd_en) begin
          e.due = ec;
          e.d   = '0;
          e.pe  = 1'b0;
          if (int'(rd_addr) < DEPTH) begin
            e.d  = m_mem[rd_addr];
            e.pe = (int'(rd_addr) == m_bad);
            if (wr_en && wr_addr == rd_addr) begin
              e.d = merge(e.d, wr_data, wr_be);
              if (wr_be[0]) e.pe = 1'b0;
            end
          end
          q0.push_back(e);
          e.due = ec + 1;
          q1.push_back(e);
        end
        if (wr_en && int'(wr_addr) < DEPTH) begin
          m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
          if (wr_be[0] && int'(wr_addr) == m_bad) m_bad = -1;
        end
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
          m_busy_left = DEPTH;
          m_bad = -1;
        end
      end
      m_v0 = 1'b0; m_p0 = 1'b0;
      if (q0.size() > 0 && q0[0].due == ec) begin
        e = q0.pop_front();
        m_v0 = 1'b1; m_d0 = e.d; m_p0 = e.pe;
      end
      m_v1 = 1'b0; m_p1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == ec) begin
        e = q1.pop_front();
        m_v1 = 1'b1; m_d1 = e.d; m_p1 = e.pe;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("init_busy_lat1", DW'(busy0), DW'(m_busy_left > 0));
      check("init_busy_lat2", DW'(busy1), DW'(m_busy_left > 0));
      check("rd_valid_lat1", DW'(rd_valid0), DW'(m_v0));
      check("rd_valid_lat2", DW'(rd_valid1), DW'(m_v1));
      check("rd_data_lat1", rd_data0, m_d0);
      check("rd_data_lat2", rd_data1, m_d1);
`ifdef NPU_SRAM_PARITY_EN
      check("parity_err_lat1", DW'(perr0), DW'(m_p0));
      check("parity_err_lat2", DW'(perr1), DW'(m_p1));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy0 && n < DEPTH + 10) begin
      n++;
      tick();
    end
    check(name, DW'(n), DW'(DEPTH));
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return AW'(DEPTH - 1);
    if (r == 1) return AW'(DEPTH + $urandom_range(0, 5));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first0, last0, cnt0, first1, last1, cnt1;
    logic [DW-1:0] x;

    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    repeat (3) tick();
    check("reset_init_busy", DW'(busy0), DW'(1));
    check("reset_rd_valid", DW'(rd_valid0), DW'(0));
    rst = 1'b0;
    count_busy("init_len_after_reset");

    // reads after init: zero
    do_read(0);
    check("read0_valid", DW'(rd_valid0), DW'(1));
    check("read0_data", rd_data0, '0);
    do_read(5);
    check("read5_data", rd_data0, '0);
    do_read(DEPTH - 1);
    check("read_last_data", rd_data0, '0);
    tick();

    // byte-enable merge
    do_write(7, {16{8'hAA}}, '1);
    do_write(7, {16{8'h55}}, 16'h00FF);
    do_read(7);
    check("byte_merge", rd_data0, {{8{8'hAA}}, {8{8'h55}}});

    // write-first collision
    do_write(3, {4{32'h1111_2222}}, '1);
    x = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = x; wr_be = '1;
    rd_en = 1'b1; rd_addr = AW'(3);
    tick();
    idle();
    check("collision_write_first", rd_data0, x);
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = pick_addr();
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : pick_addr();
      wr_be   = NB'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    idle();
    tick();

    // clr with an in-flight read, writes during INIT ignored
    do_write(7, {4{32'h7777_7777}}, '1);
    rd_en = 1'b1; rd_addr = AW'(7); clr = 1'b1;
    tick();
    idle();
    check("clr_busy_next_cycle", DW'(busy0), DW'(1));
    check("clr_inflight_read", rd_data0, {4{32'h7777_7777}});
    for (int i = 0; i < DEPTH + 10 && busy0; i++) begin
      wr_en = 1'b1; wr_addr = AW'($urandom_range(0, 15));
      wr_be = '1; wr_data = {$urandom, $urandom, $urandom, $urandom};
      rd_en = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom_range(0, 15));
      tick();
    end
    idle();
    check("clr_done", DW'(busy0), DW'(0));
    do_read(7);
    check("after_clr_addr7", rd_data0, '0);
    do_read(3);
    check("after_clr_addr3", rd_data0, '0);

    // rst mid-RUN flushes the second pipeline stage
    do_write(4, {4{32'h4444_4444}}, '1);
    do_read(4);
    rst = 1'b1;
    #1;
    check("rst_flush_lat2_valid", DW'(rd_valid1), DW'(0));
    check("rst_flush_lat2_data", rd_data1, '0);
    tick();
    check("rst_flush_lat2_hold", DW'(rd_valid1), DW'(0));
    rst = 1'b0;
    count_busy("init_len_after_rst_run");

    // rst mid-INIT at cnt=100
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("init_len_after_rst_init");

    // streaming reads 0..15
    for (int i = 0; i < 16; i++) do_write(i, {4{32'h0101_0101 * (i + 1)}}, '1);
    first0 = -1; last0 = -1; cnt0 = 0;
    first1 = -1; last1 = -1; cnt1 = 0;
    for (int k = 0; k < 20; k++) begin
      rd_en = (k < 16); rd_addr = AW'(k % 16);
      tick();
      if (rd_valid0) begin cnt0++; if (first0 < 0) first0 = k; last0 = k; end
      if (rd_valid1) begin cnt1++; if (first1 < 0) first1 = k; last1 = k; end
    end
    idle();
    check("stream_count_lat1", DW'(cnt0), DW'(16));
    check("stream_count_lat2", DW'(cnt1), DW'(16));
    check("stream_span_lat1", DW'(last0 - first0), DW'(15));
    check("stream_span_lat2", DW'(last1 - first1), DW'(15));
    check("stream_first_lat1", DW'(first0), DW'(0));
    check("stream_first_lat2", DW'(first1), DW'(1));

    // out-of-range read returns zero
    do_write(DEPTH, {4{32'hFFFF_FFFF}}, '1);
    do_read(DEPTH);
    check("oob_read_valid", DW'(rd_valid0), DW'(1));
    check("oob_read_zero", rd_data0, '0);
    tick();

`ifdef NPU_SRAM_PARITY_EN
    do_write(9, {4{32'h1234_5679}}, '1);
    u0.par[9][0] = ~u0.par[9][0];
    u1.par[9][0] = ~u1.par[9][0];
    m_bad = 9;
    do_read(9);
    check("parity_err_flagged", DW'(perr0), DW'(1));
    tick();
    tick();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
